otter_button_intr_port: RTL and testbench



---
 rtl/otter_io_pkg.sv | 26 ++
 rtl/otter_button_intr_port_debouncer.sv | 52 +++++
 rtl/otter_button_intr_port.sv | 75 +++++++
 tb/tb_otter_button_intr_port.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/otter_io_pkg.sv
// IOBUS port map shared by every OTTER input mux and output register.
// No logic and no latency: addresses, decode width and address-match helper only.
// No flow control: IOBUS is a single-cycle strobe bus with no stall.
package otter_io_pkg;

    localparam int unsigned IOBUS_AW = 32;

    // Existing board ports
    localparam logic [IOBUS_AW-1:0] SWITCHES_AD    = 32'h1100_8000;
    localparam logic [IOBUS_AW-1:0] BUTTONS_AD     = 32'h1100_8004;
    localparam logic [IOBUS_AW-1:0] LEDS_AD        = 32'h1100_C000;
    localparam logic [IOBUS_AW-1:0] SEG_AD         = 32'h1100_C004;
    localparam logic [IOBUS_AW-1:0] ANODE_AD       = 32'h1100_C008;

    // Button interrupt port
    localparam logic [IOBUS_AW-1:0] BTN_STATUS_AD  = 32'h1100_8008;
    localparam logic [IOBUS_AW-1:0] BTN_PENDING_AD = 32'h1100_800C;
    localparam logic [IOBUS_AW-1:0] BTN_MASK_AD    = 32'h1100_C00C;

    // Exact 32-bit address match; partial decodes would alias other ports.
    function automatic logic addr_hit(input logic [IOBUS_AW-1:0] addr,
                                      input logic [IOBUS_AW-1:0] port);
        return addr == port;
    endfunction

endpackage

// File: rtl/otter_button_intr_port_debouncer.sv
// One button: 2-FF synchroniser, persistence-count debounce, press pulse.
// Latency: raw edge to stable change = 2 + DEBOUNCE_CYCLES cycles; rise fires in that cycle.
// No backpressure: free-running, one sample per clock.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;
    logic          accept;

    // The changed level has persisted long enough; take it at this edge.
    assign accept = (sync != stable) && (cnt == CNT_LAST);
    assign rise   = accept && sync;

    // Two-flop synchroniser; raw is asynchronous and is read nowhere else.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (accept) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/otter_button_intr_port.sv
// Button IOBUS responder: debounced levels, W1C press-pending, mask, level INTR.
// Latency: press to PENDING = 2 + DEBOUNCE_CYCLES cycles, INTR one cycle later; reads are combinational.
// No backpressure: IOBUS writes are single-cycle strobes always accepted.
module otter_button_intr_port
    import otter_io_pkg::*;
#(
    parameter int NUM_BTNS        = 5,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_BTNS-1:0] BTN_RAW,
    input  logic [31:0]         IOBUS_ADDR,
    input  logic [31:0]         IOBUS_OUT,
    input  logic                IOBUS_WR,
    output logic [31:0]         IOBUS_IN,
    output logic                INTR,
    output logic [NUM_BTNS-1:0] BTN_LEVEL
);

    logic [NUM_BTNS-1:0] stable;
    logic [NUM_BTNS-1:0] rise;
    logic [NUM_BTNS-1:0] pending;
    logic [NUM_BTNS-1:0] mask;
    logic [NUM_BTNS-1:0] clr;
    logic                wr_pending;
    logic                wr_mask;

    // Write data bits above NUM_BTNS have no register to land in.
    logic unused_wdata;
    assign unused_wdata = ^IOBUS_OUT;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (CLK),
            .rst   (RST),
            .raw   (BTN_RAW[i]),
            .stable(stable[i]),
            .rise  (rise[i])
        );
    end

    assign wr_pending = IOBUS_WR && addr_hit(IOBUS_ADDR, BTN_PENDING_AD);
    assign wr_mask    = IOBUS_WR && addr_hit(IOBUS_ADDR, BTN_MASK_AD);
    assign clr        = wr_pending ? IOBUS_OUT[NUM_BTNS-1:0] : '0;
    assign BTN_LEVEL  = stable;

    // Pending/mask state; a new press beats a same-cycle clear of that bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending <= '0;
            mask    <= '0;
            INTR    <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | rise;
            if (wr_mask) begin
                mask <= IOBUS_OUT[NUM_BTNS-1:0];
            end
            INTR <= |(pending & mask);
        end
    end

    // Read mux; zero when the address is not ours so the top can OR it in.
    always_comb begin
        IOBUS_IN = 32'h0;
        if (addr_hit(IOBUS_ADDR, BTN_STATUS_AD)) begin
            IOBUS_IN = 32'(stable);
        end else if (addr_hit(IOBUS_ADDR, BTN_PENDING_AD)) begin
            IOBUS_IN = 32'(pending);
        end
    end

endmodule

// File: tb/tb_otter_button_intr_port.sv
// Directed bench for the button interrupt port with a short debounce window.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// Bus writes are one-cycle strobes.
module tb_otter_button_intr_port;

    localparam int NB = 5;
    localparam int DC = 4;

    localparam logic [31:0] A_SW   = 32'h1100_8000;
    localparam logic [31:0] A_STAT = 32'h1100_8008;
    localparam logic [31:0] A_PEND = 32'h1100_800C;
    localparam logic [31:0] A_MASK = 32'h1100_C00C;

    logic          CLK = 1'b0;
    logic          RST;
    logic [NB-1:0] BTN_RAW;
    logic [31:0]   IOBUS_ADDR;
    logic [31:0]   IOBUS_OUT;
    logic          IOBUS_WR;
    logic [31:0]   IOBUS_IN;
    logic          INTR;
    logic [NB-1:0] BTN_LEVEL;

    int n_cmp = 0;
    int n_err = 0;

    otter_button_intr_port #(
        .NUM_BTNS       (NB),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .BTN_RAW   (BTN_RAW),
        .IOBUS_ADDR(IOBUS_ADDR),
        .IOBUS_OUT (IOBUS_OUT),
        .IOBUS_WR  (IOBUS_WR),
        .IOBUS_IN  (IOBUS_IN),
        .INTR      (INTR),
        .BTN_LEVEL (BTN_LEVEL)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        IOBUS_ADDR = addr;
        #1;
        chk(tag, IOBUS_IN, exp);
        IOBUS_ADDR = 32'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        IOBUS_WR   = 1'b1;
        step(1);
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = 32'h0;
        IOBUS_OUT  = 32'h0;
    endtask

    initial begin
        // 1. reset with all buttons driven high
        RST = 1'b1; BTN_RAW = 5'h1F; IOBUS_ADDR = 32'h0; IOBUS_OUT = 32'h0; IOBUS_WR = 1'b0;
        step(3);
        chk("rst_intr", {31'h0, INTR}, 32'h0);
        chk("rst_level", {27'h0, BTN_LEVEL}, 32'h0);
        RST = 1'b0; BTN_RAW = 5'h00;
        step(1);
        chk_rd("rst_status", A_STAT, 32'h0);
        chk_rd("rst_pending", A_PEND, 32'h0);
        chk("rst_intr2", {31'h0, INTR}, 32'h0);

        // 2. single press on btn0 with mask bit0 enabled
        wr(A_MASK, 32'h1);
        BTN_RAW = 5'h01;
        step(5);
        chk_rd("press_status_early", A_STAT, 32'h0);
        chk_rd("press_pending_early", A_PEND, 32'h0);
        step(1);
        chk_rd("press_status", A_STAT, 32'h1);
        chk_rd("press_pending", A_PEND, 32'h1);
        chk("press_intr_early", {31'h0, INTR}, 32'h0);
        chk("press_level", {27'h0, BTN_LEVEL}, 32'h01);
        step(1);
        chk("press_intr", {31'h0, INTR}, 32'h1);

        // 3. btn1 bouncing every 2 cycles never qualifies (INTR watches btn1 only)
        wr(A_MASK, 32'h2);
        for (int i = 0; i < 10; i++) begin
            BTN_RAW[1] = ~BTN_RAW[1];
            step(2);
        end
        BTN_RAW[1] = 1'b0;
        step(4);
        chk_rd("glitch_status", A_STAT, 32'h1);
        chk_rd("glitch_pending", A_PEND, 32'h1);
        chk("glitch_intr", {31'h0, INTR}, 32'h0);

        // 4. clear bit0 in the cycle btn2 is accepted
        BTN_RAW = 5'h05;
        step(5);
        wr(A_PEND, 32'h1);
        chk_rd("w1c_pending", A_PEND, 32'h4);
        chk_rd("w1c_status", A_STAT, 32'h5);
        BTN_RAW = 5'h01;
        step(6);
        chk_rd("rel2_status", A_STAT, 32'h1);
        chk_rd("rel2_pending", A_PEND, 32'h4);
        BTN_RAW = 5'h05;
        step(5);
        wr(A_PEND, 32'h4);
        chk_rd("setwins_pending", A_PEND, 32'h4);
        wr(A_STAT, 32'h1F);
        chk_rd("ro_write_pending", A_PEND, 32'h4);
        chk("masked_intr", {31'h0, INTR}, 32'h0);

        // 5. mask gating and W1C of INTR; releases set nothing
        wr(A_MASK, 32'h0);
        wr(A_PEND, 32'h4);
        chk_rd("clr_pending", A_PEND, 32'h0);
        BTN_RAW = 5'h04;
        step(6);
        chk_rd("rel0_status", A_STAT, 32'h4);
        chk_rd("rel0_pending", A_PEND, 32'h0);
        BTN_RAW = 5'h05;
        step(6);
        chk_rd("repress_pending", A_PEND, 32'h1);
        step(1);
        chk("mask0_intr", {31'h0, INTR}, 32'h0);
        wr(A_MASK, 32'h1);
        chk("mask_wr_intr_same", {31'h0, INTR}, 32'h0);
        chk_rd("mask_not_readable", A_MASK, 32'h0);
        step(1);
        chk("mask_wr_intr", {31'h0, INTR}, 32'h1);
        wr(A_PEND, 32'h1);
        chk_rd("w1c0_pending", A_PEND, 32'h0);
        chk("w1c0_intr_same", {31'h0, INTR}, 32'h1);
        step(1);
        chk("w1c0_intr", {31'h0, INTR}, 32'h0);

        // 6. reset mid-debounce of btn3 with buttons still held
        BTN_RAW = 5'h0D;
        step(4);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        chk("mid_rst_level", {27'h0, BTN_LEVEL}, 32'h0);
        chk_rd("mid_rst_pending", A_PEND, 32'h0);
        chk("mid_rst_intr", {31'h0, INTR}, 32'h0);
        step(5);
        chk_rd("restart_status_early", A_STAT, 32'h0);
        step(1);
        chk_rd("restart_status", A_STAT, 32'hD);
        chk_rd("restart_pending", A_PEND, 32'hD);
        chk_rd("foreign_addr", A_SW, 32'h0);
        step(1);
        chk("restart_intr", {31'h0, INTR}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
